// File: rtl/mult_booth32.sv
// mult_booth32: multi-cycle 32x32 signed radix-2 Booth multiplier.
// One CLA_32 adder performs every partial-product add/subtract; its overflow
// flag corrects the sign bit shifted into the product register.
// Optional build macro: MULT_RESTART_EN -- when defined, a start request
// during RUN reloads the operands and restarts the operation.

// 32-bit carry-lookahead adder built from 4-bit lookahead groups.
module CLA_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        ovf_o
);

  logic [31:0] gen_s;
  logic [31:0] prop_s;
  logic        grp_carry_s;
  logic        bit_carry_s;
  logic        grp_gen_s;
  logic        grp_prop_s;
  logic        carry_in31_s;

  assign gen_s  = a_i & b_i;
  assign prop_s = a_i ^ b_i;

  // Group lookahead carries between 4-bit groups, ripple inside each group.
  always_comb begin
    sum_o        = 32'd0;
    grp_carry_s  = cin_i;
    bit_carry_s  = 1'b0;
    grp_gen_s    = 1'b0;
    grp_prop_s   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      grp_gen_s  = gen_s[4*k+3]
                 | (prop_s[4*k+3] & gen_s[4*k+2])
                 | (prop_s[4*k+3] & prop_s[4*k+2] & gen_s[4*k+1])
                 | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k]);
      grp_prop_s = &prop_s[4*k +: 4];
      bit_carry_s = grp_carry_s;
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = prop_s[4*k+j] ^ bit_carry_s;
        bit_carry_s  = gen_s[4*k+j] | (prop_s[4*k+j] & bit_carry_s);
      end
      grp_carry_s = grp_gen_s | (grp_prop_s & grp_carry_s);
    end
    // Carry into the MSB is recovered from the MSB sum and propagate bits.
    carry_in31_s = sum_o[31] ^ prop_s[31];
    ovf_o        = carry_in31_s ^ grp_carry_s;
  end

endmodule

module mult_booth32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [64:0] p_q, p_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic        start_s;
  logic [1:0]  booth_sel_s;
  logic        do_sub_s;
  logic [31:0] add_b_s;
  logic [31:0] sum_s;
  logic        ovf_s;
  logic [64:0] p_step_s;

  assign booth_sel_s = p_q[1:0];
  assign do_sub_s    = (booth_sel_s == 2'b10);
  assign add_b_s     = do_sub_s ? ~m_q : m_q;

  CLA_32 u_cla (
    .a_i   (p_q[64:33]),
    .b_i   (add_b_s),
    .cin_i (do_sub_s),
    .sum_o (sum_s),
    .ovf_o (ovf_s)
  );

  // One Booth step: optional add/subtract of M into HI, then arithmetic shift right.
  always_comb begin
    p_step_s = p_q;
    case (booth_sel_s)
      2'b01, 2'b10: p_step_s = {sum_s[31] ^ ovf_s, sum_s, p_q[32:1]};
      default:      p_step_s = {p_q[64], p_q[64:33], p_q[32:1]};
    endcase
  end

  // Decide whether a start request is accepted in the current state.
  always_comb begin
    start_s = 1'b0;
    case (state_q)
      ST_IDLE: start_s = ctrl_MULT;
      ST_DONE: start_s = ctrl_MULT;
`ifdef MULT_RESTART_EN
      ST_RUN:  start_s = ctrl_MULT;
`else
      ST_RUN:  start_s = 1'b0;
`endif
      default: start_s = 1'b0;
    endcase
  end

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_d      = p_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (start_s) begin
      m_d     = data_operandA;
      p_d     = {32'd0, data_operandB, 1'b0};
      count_d = 5'd0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          p_d     = p_step_s;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            // Last iteration: capture the product straight from the step result.
            state_d  = ST_DONE;
            result_d = p_step_s[32:1];
            exc_d    = (p_step_s[64:33] != {32{p_step_s[32]}});
            rdy_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      m_q      <= 32'd0;
      p_q      <= 65'd0;
      count_q  <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      p_q      <= p_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_booth32.sv
// Directed self-checking bench for mult_booth32.
module tb_mult_booth32;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int tests_run;
  int tests_failed;

  mult_booth32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for the ready strobe; lat = edges waited (0 if budget expired).
  task automatic wait_rdy(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (data_resultRDY === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e);
    int lat;
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    wait_rdy(40, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd32);
    check_eq({tag, "_result"}, data_result, exp_r);
    check_eq({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
    tick();
    check_eq({tag, "_rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int lat;
    int strobes;
    int strobe_edge;
    logic [31:0] strobe_val;

    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    tick();
    tick();
    check_eq("reset_result", data_result, 32'd0);
    check_eq("reset_exc", {31'd0, data_exception}, 32'd0);
    check_eq("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    tick();

    run_mult("3x5",      32'd3,          32'd5,          32'd15,         1'b0);
    run_mult("m7x6",     32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6,  1'b0);
    run_mult("6xm7",     32'd6,          32'hFFFF_FFF9,  32'hFFFF_FFD6,  1'b0);
    run_mult("0xm1",     32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0);
    run_mult("max_x2",   32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1);
    run_mult("min_xm1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);

    // Back-to-back: second start accepted in the DONE cycle.
    ctrl_MULT = 1'b1; data_operandA = 32'd4; data_operandB = 32'd4;
    tick();
    ctrl_MULT = 1'b0;
    wait_rdy(40, lat);
    check_eq("b2b_first_latency", 32'(lat), 32'd32);
    check_eq("b2b_first_result", data_result, 32'd16);
    ctrl_MULT = 1'b1; data_operandA = 32'hFFFF_FFFF; data_operandB = 32'hFFFF_FFFF;
    tick();
    ctrl_MULT = 1'b0;
    check_eq("b2b_strobe_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    wait_rdy(40, lat);
    check_eq("b2b_second_spacing", 32'(lat + 1), 32'd33);
    check_eq("b2b_second_result", data_result, 32'd1);
    check_eq("b2b_second_exc", {31'd0, data_exception}, 32'd0);
    tick();

    // Reset at iteration 10 aborts the operation.
    ctrl_MULT = 1'b1; data_operandA = 32'd100; data_operandB = 32'd100;
    tick();
    ctrl_MULT = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_result", data_result, 32'd0);
    check_eq("abort_exc", {31'd0, data_exception}, 32'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY === 1'b1) strobes++;
      tick();
    end
    check_eq("abort_no_strobe", 32'(strobes), 32'd0);
    run_mult("after_abort_2x3", 32'd2, 32'd3, 32'd6, 1'b0);

    // Start request in the middle of RUN (iteration 5).
    ctrl_MULT = 1'b1; data_operandA = 32'd2; data_operandB = 32'd2;
    tick();
    ctrl_MULT = 1'b0;
    repeat (4) tick();
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    tick();
    ctrl_MULT = 1'b0;
    strobes     = 0;
    strobe_edge = 0;
    strobe_val  = 32'd0;
    for (int e = 6; e <= 50; e++) begin
      tick();
      if (data_resultRDY === 1'b1) begin
        strobes++;
        strobe_edge = e;
        strobe_val  = data_result;
      end
    end
    check_eq("midrun_strobe_count", 32'(strobes), 32'd1);
`ifdef MULT_RESTART_EN
    check_eq("midrun_strobe_edge", 32'(strobe_edge), 32'd37);
    check_eq("midrun_result", strobe_val, 32'd81);
`else
    check_eq("midrun_strobe_edge", 32'(strobe_edge), 32'd32);
    check_eq("midrun_result", strobe_val, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
